// File: rtl/zfetch.sv
// zfetch: depth-fetch stage between the rasterizer and ztest. Each accepted pixel
// issues one Avalon read of its stored depth and waits in a FIFO for that depth.
module zfetch #(
  parameter int ADDR_W       = 26,
  parameter int PENDING      = 4,
  parameter int DEPTH_OFFSET = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_color,
  input  logic [31:0]       in_depth,
  input  logic              in_done,
  input  logic              stall_in,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_color,
  output logic [31:0]       out_old_depth,
  output logic [31:0]       out_new_depth,
  output logic              out_done,
  output logic              err,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [3:0]        master_byteenable,
  output logic [31:0]       master_writedata,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  input  logic              master_waitrequest,
  output logic              fsm_state
);

  // Handshakes: a pixel transfers on a rising edge with in_valid && in_ready, and
  // in_ready never looks at in_valid. A read is accepted by the slave on an edge with
  // master_read && !master_waitrequest. Read data returns in order and cannot be
  // back-pressured, so every readdatavalid is consumed on the edge it is seen.

  localparam int PTR_W = $clog2(PENDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] q_addr  [PENDING];
  logic [31:0]       q_color [PENDING];
  logic [31:0]       q_depth [PENDING];
  logic              q_done  [PENDING];

  logic push;
  logic pop;
  logic stray;

  assign in_ready = (state == S_IDLE) && !stall_in && (count < CNT_W'(PENDING));
  assign push     = in_valid && in_ready;
  assign pop      = master_readdatavalid && (count != '0);
  assign stray    = master_readdatavalid && (count == '0);

  assign master_write      = 1'b0;
  assign master_byteenable = 4'hF;
  assign master_writedata  = 32'd0;
  assign fsm_state         = state;

  // Request FSM: one read per accepted pixel; address and read stay put until the
  // slave drops waitrequest.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      master_read    <= 1'b0;
      master_address <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (push) begin
            master_address <= in_addr + ADDR_W'(DEPTH_OFFSET);
            master_read    <= 1'b1;
            state          <= S_REQ;
          end
        end
        S_REQ: begin
          if (!master_waitrequest) begin
            master_read <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clock) begin
    if (push) begin
      q_addr[wr_ptr]  <= in_addr;
      q_color[wr_ptr] <= in_color;
      q_depth[wr_ptr] <= in_depth;
      q_done[wr_ptr]  <= in_done;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_color     <= '0;
      out_old_depth <= '0;
      out_new_depth <= '0;
      out_done      <= 1'b0;
      err           <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_addr      <= q_addr[rd_ptr];
        out_color     <= q_color[rd_ptr];
        out_old_depth <= master_readdata;
        out_new_depth <= q_depth[rd_ptr];
        out_done      <= q_done[rd_ptr];
      end
      // A return with nothing pending is dropped but remembered until reset.
      if (stray) err <= 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    count <= CNT_W'(PENDING));

  a_req_hold: assert property (@(posedge clock) disable iff (!reset)
    (master_read && master_waitrequest) |=> (master_read && $stable(master_address)));

endmodule

// File: tb/tb_zfetch.sv
// Bench for zfetch: directed scenarios plus random traffic against an Avalon slave
// model, every cycle compared with a queue-based reference of the pixel stream.
module tb_zfetch;

  localparam int ADDR_W       = 26;
  localparam int PENDING      = 4;
  localparam int DEPTH_OFFSET = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [31:0]       in_color = '0;
  logic [31:0]       in_depth = '0;
  logic              in_done = 1'b0;
  logic              stall_in = 1'b0;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_color;
  logic [31:0]       out_old_depth;
  logic [31:0]       out_new_depth;
  logic              out_done;
  logic              err;
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic              master_write;
  logic [3:0]        master_byteenable;
  logic [31:0]       master_writedata;
  logic [31:0]       master_readdata = '0;
  logic              master_readdatavalid = 1'b0;
  logic              master_waitrequest = 1'b0;
  logic              fsm_state;

  zfetch #(.ADDR_W(ADDR_W), .PENDING(PENDING), .DEPTH_OFFSET(DEPTH_OFFSET)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_color(in_color),
    .in_depth(in_depth), .in_done(in_done), .stall_in(stall_in),
    .out_valid(out_valid), .out_addr(out_addr), .out_color(out_color),
    .out_old_depth(out_old_depth), .out_new_depth(out_new_depth), .out_done(out_done),
    .err(err), .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_byteenable(master_byteenable),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_waitrequest(master_waitrequest),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_depth(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // ---------------- Avalon slave model ----------------
  logic [ADDR_W-1:0] sq_addr[$];
  int                sq_due[$];
  int   slave_cycle   = 0;
  int   accept_cnt    = 0;
  bit   manual_wr     = 1'b1;
  bit   manual_wr_val = 1'b0;
  bit   ret_en        = 1'b1;
  bit   spurious      = 1'b0;
  bit   fixed_en      = 1'b1;
  logic [31:0] fixed_data = 32'd9;
  int   lat_min = 3;
  int   lat_max = 3;
  int   wr_pct  = 0;

  always @(negedge reset) begin
    sq_addr.delete();
    sq_due.delete();
  end

  initial begin
    bit                acc;
    logic [ADDR_W-1:0] acc_addr;
    forever begin
      @(negedge clock);
      acc      = reset && master_read && !master_waitrequest;
      acc_addr = master_address;
      @(posedge clock);
      #1;
      slave_cycle++;
      if (acc) begin
        sq_addr.push_back(acc_addr);
        sq_due.push_back(slave_cycle + int'($urandom_range(lat_max, lat_min)));
        accept_cnt++;
      end
      if (spurious) begin
        master_readdatavalid = 1'b1;
        master_readdata      = $urandom;
        spurious             = 1'b0;
      end else if (ret_en && sq_addr.size() > 0 && sq_due[0] <= slave_cycle) begin
        master_readdatavalid = 1'b1;
        master_readdata      = fixed_en ? fixed_data : mem_depth(sq_addr[0]);
        void'(sq_addr.pop_front());
        void'(sq_due.pop_front());
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata      = $urandom;
      end
      master_waitrequest = manual_wr ? manual_wr_val : (int'($urandom_range(99, 0)) < wr_pct);
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       color;
    logic [31:0]       depth;
    logic              done;
  } pix_t;

  pix_t              pq[$];
  bit                m_busy;
  logic [ADDR_W-1:0] m_addr;
  bit                m_ov;
  pix_t              m_out;
  logic [31:0]       m_old;
  bit                m_err;

  int                dut_beats = 0;
  logic [ADDR_W-1:0] la_addr;
  logic [31:0]       la_color, la_old, la_new;
  logic              la_done;

  initial begin
    bit   exp_rdy;
    pix_t p;
    forever begin
      @(negedge clock);
      if (!reset) begin
        pq.delete();
        m_busy = 1'b0; m_addr = '0; m_ov = 1'b0; m_err = 1'b0; m_old = '0;
        m_out.addr = '0; m_out.color = '0; m_out.depth = '0; m_out.done = 1'b0;
        continue;
      end
      exp_rdy = !m_busy && !stall_in && (pq.size() < PENDING);
      check("in_ready",       64'(in_ready),       64'(exp_rdy));
      check("master_read",    64'(master_read),    64'(m_busy));
      check("fsm_state",      64'(fsm_state),      64'(m_busy));
      check("master_address", 64'(master_address), 64'(m_addr));
      check("out_valid",      64'(out_valid),      64'(m_ov));
      check("out_addr",       64'(out_addr),       64'(m_out.addr));
      check("out_color",      64'(out_color),      64'(m_out.color));
      check("out_old_depth",  64'(out_old_depth),  64'(m_old));
      check("out_new_depth",  64'(out_new_depth),  64'(m_out.depth));
      check("out_done",       64'(out_done),       64'(m_out.done));
      check("err",            64'(err),            64'(m_err));
      check("tie_offs", 64'({master_write, master_byteenable, master_writedata}), 64'({1'b0, 4'hF, 32'd0}));
      if (out_valid) begin
        dut_beats++;
        la_addr = out_addr; la_color = out_color; la_old = out_old_depth;
        la_new = out_new_depth; la_done = out_done;
      end
      // what must happen at the coming edge
      m_ov = 1'b0;
      if (master_readdatavalid) begin
        if (pq.size() > 0) begin
          m_out = pq.pop_front();
          m_old = master_readdata;
          m_ov  = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_busy) begin
        if (!master_waitrequest) m_busy = 1'b0;
      end else if (in_valid && exp_rdy) begin
        m_busy = 1'b1;
        m_addr = in_addr + ADDR_W'(DEPTH_OFFSET);
        p.addr = in_addr; p.color = in_color; p.depth = in_depth; p.done = in_done;
        pq.push_back(p);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_pixel(input logic [ADDR_W-1:0] a, input logic [31:0] c,
                            input logic [31:0] d, input logic dn);
    bit got = 1'b0;
    in_valid = 1'b1; in_addr = a; in_color = c; in_depth = d; in_done = dn;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      got = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_pixel timeout actual=no_handshake required=handshake addr=%0h", a);
    end
  endtask

  task automatic wait_beats(input int target, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      ok = (dut_beats >= target);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s beats actual=%0d required=%0d", name, dut_beats, target);
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int b0, a0, hi;
    bit drained;

    // reset state
    @(negedge clock);
    check("rst_master_read", 64'(master_read), 64'd0);
    check("rst_master_address", 64'(master_address), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'({out_addr, out_done}), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clock); #3 reset = 1'b1;
    @(posedge clock); #1;

    // single pixel, read data 9 three cycles later
    b0 = dut_beats;
    send_pixel(26'd100, 32'h0000FF00, 32'd5, 1'b0);
    @(negedge clock);
    check("single_read", 64'(master_read), 64'd1);
    check("single_addr", 64'(master_address), 64'd104);
    @(posedge clock); #1;
    @(negedge clock);
    check("single_read_drop", 64'(master_read), 64'd0);
    @(posedge clock); #1;
    wait_beats(b0 + 1, "single");
    check("single_out", 64'({la_addr, la_done}), 64'({26'd100, 1'b0}));
    check("single_color", 64'(la_color), 64'h0000FF00);
    check("single_depths", 64'({la_old, la_new}), 64'({32'd9, 32'd5}));
    fixed_en = 1'b0;

    // waitrequest held for four cycles
    @(negedge clock); manual_wr_val = 1'b1;
    @(posedge clock); #1;
    a0 = accept_cnt; b0 = dut_beats; hi = 0;
    send_pixel(26'd200, 32'h12345678, 32'd77, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!master_read) break;
      hi++;
      check("hold_addr", 64'(master_address), 64'd204);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      if (hi == 4) manual_wr_val = 1'b0;
    end
    check("hold_read_cycles", 64'(hi), 64'd5);
    check("hold_one_read", 64'(accept_cnt - a0), 64'd1);
    @(posedge clock); #1;
    wait_beats(b0 + 1, "hold");

    // backlog: six pixels with returns held back
    @(negedge clock); ret_en = 1'b0; lat_min = 1;
    @(posedge clock); #1;
    a0 = accept_cnt; b0 = dut_beats;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_pixel(ADDR_W'(1000 + i * 8), $urandom, $urandom, (i == 5));
      end
      begin
        wait_cycles(20);
        @(negedge clock);
        check("backlog_in_ready", 64'(in_ready), 64'd0);
        check("backlog_reads", 64'(accept_cnt - a0), 64'd4);
        ret_en = 1'b1;
      end
    join
    wait_beats(b0 + 6, "backlog");
    check("backlog_last", 64'({la_addr, la_done}), 64'({26'd1040, 1'b1}));

    // stall with two reads outstanding
    @(negedge clock); ret_en = 1'b0; lat_max = 2;
    @(posedge clock); #1;
    a0 = accept_cnt; b0 = dut_beats;
    send_pixel(26'd2000, 32'hA, 32'hB, 1'b0);
    send_pixel(26'd2008, 32'hC, 32'hD, 1'b0);
    stall_in = 1'b1;
    in_valid = 1'b1; in_addr = 26'd2016; in_color = 32'hE; in_depth = 32'hF; in_done = 1'b1;
    wait_cycles(4);
    @(negedge clock); ret_en = 1'b1;
    wait_beats(b0 + 2, "stall");
    @(negedge clock);
    check("stall_reads", 64'(accept_cnt - a0), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    stall_in = 1'b0;
    @(negedge clock);
    check("unstall_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("unstall_read", 64'({master_read, master_address}), 64'({1'b1, 26'd2020}));
    @(posedge clock); #1;
    wait_beats(b0 + 3, "unstall");

    // stray return with empty queue
    b0 = dut_beats;
    @(negedge clock); spurious = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("stray_err", 64'(err), 64'd1);
    check("stray_no_beat", 64'({out_valid, 32'(dut_beats - b0)}), 64'd0);
    @(posedge clock); #1;

    // address wrap
    b0 = dut_beats;
    send_pixel(26'h3FFFFFE, 32'h55, 32'h66, 1'b0);
    @(negedge clock);
    check("wrap_addr", 64'(master_address), 64'd2);
    @(posedge clock); #1;
    wait_beats(b0 + 1, "wrap");

    // asynchronous reset while a read is stuck in waitrequest
    @(negedge clock); manual_wr_val = 1'b1;
    @(posedge clock); #1;
    send_pixel(26'd300, 32'h1, 32'h2, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_master_read", 64'(master_read), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    check("arst_idle_empty", 64'({in_ready, fsm_state}), 64'({1'b1, 1'b0}));
    @(negedge clock); manual_wr_val = 1'b0;
    @(posedge clock); #3 reset = 1'b1;
    @(posedge clock); #1;

    // random traffic
    @(negedge clock); manual_wr = 1'b0; wr_pct = 30; lat_min = 1; lat_max = 6;
    @(posedge clock); #1;
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1'($urandom_range(1, 0));
      stall_in = ($urandom_range(9, 0) == 0);
      in_addr  = ($urandom_range(7, 0) == 0) ? ADDR_W'(26'h3FFFFF8 + $urandom_range(7, 0))
                                             : ADDR_W'($urandom);
      in_color = $urandom;
      in_depth = $urandom;
      in_done  = 1'($urandom_range(1, 0));
      @(posedge clock); #1;
    end
    in_valid = 1'b0; stall_in = 1'b0;

    drained = 1'b0;
    for (int i = 0; i < 500 && !drained; i++) begin
      @(negedge clock);
      drained = (pq.size() == 0) && !m_busy && !out_valid;
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL drain actual=pending%0d required=pending0", pq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
